// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The master drives the operands and out_ready; the slave is the pipeline itself.
interface logic_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_ones;
    logic             out_parity;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_ones, out_parity
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with a global valid/ready stall.
// Define LOGIC_UNIT_COUNT_EN to add a saturating 16-bit output beat counter (beat_count).
module logic_unit_pipe #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    logic_unit_if.slave  bus
`ifdef LOGIC_UNIT_COUNT_EN
    ,
    output logic [15:0]  beat_count
`endif
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("logic_unit_pipe: WIDTH must be in 1..64");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $error("logic_unit_pipe: PIPE_STAGES must be in 1..4");
    end

    typedef struct packed {
        logic             valid;
        logic             zero;
        logic             ones;
        logic             parity;
        logic [WIDTH-1:0] y;
    } stage_t;

    stage_t           stage_q [PIPE_STAGES];
    stage_t           stage_d [PIPE_STAGES];
    logic             advance;
    logic [WIDTH-1:0] res;

    // Stall the whole pipe only when the output holds an unaccepted beat.
    assign advance = !stage_q[PIPE_STAGES-1].valid || bus.out_ready;

    always_comb begin
        res = '0;
        case (bus.in_op)
            3'd0:    res = bus.in_a & bus.in_b;
            3'd1:    res = bus.in_a | bus.in_b;
            3'd2:    res = bus.in_a ^ bus.in_b;
            3'd3:    res = ~(bus.in_a & bus.in_b);
            3'd4:    res = ~(bus.in_a | bus.in_b);
            3'd5:    res = ~(bus.in_a ^ bus.in_b);
            3'd6:    res = ~bus.in_a;
            3'd7:    res = bus.in_a;
            default: res = '0;
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        if (advance) begin
            stage_d[0] = '{valid:  bus.in_valid,
                           zero:   (res == '0),
                           ones:   (&res),
                           parity: (^res),
                           y:      res};
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.in_ready   = advance;
    assign bus.out_valid  = stage_q[PIPE_STAGES-1].valid;
    assign bus.out_y      = stage_q[PIPE_STAGES-1].y;
    assign bus.out_zero   = stage_q[PIPE_STAGES-1].zero;
    assign bus.out_ones   = stage_q[PIPE_STAGES-1].ones;
    assign bus.out_parity = stage_q[PIPE_STAGES-1].parity;

`ifdef LOGIC_UNIT_COUNT_EN
    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (bus.out_valid && bus.out_ready && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign beat_count = count_q;
`endif

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the single-bit two-input gate.
- Applies one of eight selectable bitwise operations to two WIDTH-bit operands.
- Result travels through PIPE_STAGES registered stages with valid/ready handshakes on both sides, plus status flags.
- Sits between an operand producer and a result consumer inside datapath test fixtures and small ALUs.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- PIPE_STAGES, 2, number of register stages from input handshake to output; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts the operand beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  3  operation select; encoding given under Behaviour.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result beat.
- out_y  output  WIDTH  result.
- out_zero  output  1  out_y == 0.
- out_ones  output  1  out_y is all ones.
- out_parity  output  1  XOR-reduction of out_y.

Behaviour:
- Operation encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR: all bitwise on a and b.
  - 6 NOT a; b is ignored.
  - 7 PASS a; b is ignored.
- Input handshake: a beat transfers on a rising edge when in_valid && in_ready.
- Output handshake: a beat transfers on a rising edge when out_valid && out_ready.
- Global stall scheme:
  - advance = !out_valid || out_ready.
  - in_ready = advance; this is a combinational path from out_ready.
- Pipeline movement:
  - When advance is 1, every stage shifts one position toward the output.
  - Stage 1 captures the computed result together with valid = in_valid.
  - When advance is 0, every stage holds, including its valid bit.
- Computation is performed combinationally on the input side and registered into stage 1.
- The zero, ones and parity flags are computed at stage 1 and carried alongside the result.
- Latency: with out_ready held at 1, the result is on out_y exactly PIPE_STAGES cycles after the input handshake edge.
- Throughput: one beat per cycle when unstalled.
- Bubbles: empty stages are not collapsed. A bubble ahead of the output still causes a stall while out_valid=1 and out_ready=0.
- Stability: while out_valid=1 and out_ready=0, out_y, out_valid and all flags hold constant.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- Simultaneous input and output handshake in the same cycle: both complete; the pipeline shifts by one.
- Reset:
  - rst_n low clears every stage valid bit, data register and flag to 0 immediately, without waiting for a clock edge.
  - Output reset values: out_valid=0, out_y=0, out_zero=0, out_ones=0, out_parity=0.
  - in_ready=1 during and after reset, since out_valid=0.
  - Reset asserted mid-operation discards all in-flight beats.
  - The first edge after rst_n deasserts may accept a new beat.
- Flags while out_valid=0 are don't-care; the bench must not check them.
- WIDTH=1 must reproduce the plain two-input gate truth tables exactly.
- Illegal parameter values stop elaboration with an error.

Optional Feature:
- Macro: LOGIC_UNIT_COUNT_EN.
- When defined:
  - Adds output port beat_count (16 bits).
  - beat_count increments by 1 on every output handshake and saturates at 0xFFFF.
  - beat_count resets to 0 asynchronously with rst_n.
- When undefined:
  - The port and counter logic are absent.
  - All other behaviour is unchanged.

Test Plan:
- WIDTH=1, PIPE_STAGES=1, out_ready=1; sweep every op across (a,b) = 00, 01, 10, 11 -> out_y matches the gate truth table one cycle later. Example: AND gives 0,0,0,1.
- WIDTH=8, PIPE_STAGES=2; op=0, a=0xF0, b=0x3C -> out_y=0x30 two cycles after acceptance, out_zero=0, out_parity=0. Then op=2, a=b=0xAA -> out_y=0x00, out_zero=1.
- Back-to-back beats: op=1 with a = 0x01, 0x02, 0x04, 0x08 and b=0x00 on consecutive cycles, out_ready=1 -> out_y = 0x01, 0x02, 0x04, 0x08 on consecutive cycles, with no gaps.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0 and out_y/flags stable throughout. Release -> all beats emerge in order, none lost.
- Reset mid-stream: assert rst_n=0 between clock edges with 2 beats in flight -> out_valid=0 and out_y=0 immediately. After release, the first new beat op=3, a=0xFF, b=0xFF -> out_y=0x00, out_zero=1.
- With LOGIC_UNIT_COUNT_EN defined: 10 output handshakes -> beat_count=10. Force the counter to 0xFFFE, then 3 handshakes -> beat_count=0xFFFF.
